downlink_sequencer: RTL
=======================

# downlink_sequencer

Controller for the simulated PCM telemetry path between the AGC core and the monitor. Derives downlink timing from the AGC `CLK` output and issues the `DKSTRT`/`DKBSNC`/`DKEND` strobes to the AGC. It shifts in the 40 `DKDATA` bits of each frame and hands the completed word to a downstream consumer, such as a UART streamer, over a valid/ready handshake. It replaces the free-running PCM counter logic at the top level and adds enable/abort control, word capture and overrun reporting.

## Interface
- `PULSE_LEN`, 4: length of each strobe, in AGC CLK ticks.
- `SLOT_LEN`, 20: length of one bit slot, in ticks (must be > `PULSE_LEN`).
- `FRAME_SLOTS`, 1024: slots per frame period.
- `clk`  in  1  system clock. One clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  sequencer run enable.
- `agc_clk_in`  in  1  AGC CLK output, asynchronous to `clk`.
- `dkdata`  in  1  AGC downlink serial data, asynchronous.
- `word_ready`  in  1  consumer accepts `word_data`.
- `dkstrt`, `dkbsnc`, `dkend`  out  1  strobes to the AGC.
- `word_data`  out  40  last captured frame; frame bit 1 is in bit 39.
- `word_valid`  out  1  `word_data` is pending.
- `overrun`  out  1  sticky; a frame was dropped.
- `overrun_clr`  in  1  clears `overrun`.
- `frame_count`  out  16  completed frames (including dropped frames), wraps.

## Operation
- **Synchronisers:** `agc_clk_in` and `dkdata` each pass through a 2-flop synchroniser. A third flop on the clock path detects the rising edge. `tick` is a one-`clk` pulse on each synchronised rising edge of `agc_clk_in`. `dkdata` has the same sync depth, so it stays aligned with `tick`.
- **Counters:**
  - `pulse_cnt`: 0..`SLOT_LEN`-1.
  - `slot_cnt`: 0..`FRAME_SLOTS`-1.
  - `bit_idx`: 0..42.
- **Counter update on `tick`:**
  - `pulse_cnt` increments.
  - At `pulse_cnt`==`SLOT_LEN`-1, `pulse_cnt` wraps to 0 and `slot_cnt` increments modulo `FRAME_SLOTS`.
  - On that same wrap: if `slot_cnt`==`FRAME_SLOTS`-1, then `bit_idx`<=0; else if `bit_idx`<42, `bit_idx`++; otherwise `bit_idx` holds at 42.
- **Frame phases, by `bit_idx`:** 0 = START, 1..40 = BITS, 41 = END, 42 = GAP.
- **Strobe decode** (from registered state, no added latency, all gated by `enable`):
  - `dkstrt` = (`pulse_cnt`<`PULSE_LEN`) & (`bit_idx`==0).
  - `dkbsnc` = (`pulse_cnt`<`PULSE_LEN`) & (1≤`bit_idx`≤40).
  - `dkend` = (`pulse_cnt`<`PULSE_LEN`) & (`bit_idx`==41).
- **Capture:**
  - On the `tick` that advances `pulse_cnt` from `PULSE_LEN`-1 to `PULSE_LEN` while 1≤`bit_idx`≤40: shift left, `shreg`<={`shreg`[38:0], synced `dkdata`}.
  - On the same `tick` condition with `bit_idx`==41 (the frame commit): `frame_count`++.
    - If `word_valid`==0, or `word_ready`==1 in that cycle: `word_data`<=`shreg` and `word_valid`<=1.
    - Otherwise: the new frame is dropped, `word_data` is unchanged, and `overrun`<=1.
- **Handshake:** transfer happens when `word_valid`&`word_ready`. `word_valid` falls the next cycle unless a commit coincides. `word_data` is stable while `word_valid`=1.
- **Overrun flag:** `overrun_clr` clears `overrun`. If a set and a clear happen in the same cycle, set wins.
- **`enable`=0:** counters are forced to their reset values, `shreg` clears, and all strobes are 0. A frame in progress is aborted without commit. `word_valid`, `word_data`, `overrun` and `frame_count` are preserved and the handshake still works.
- **Reset values:**
  - `pulse_cnt`=0, `slot_cnt`=`FRAME_SLOTS`-1, `bit_idx`=42, `shreg`=0.
  - All outputs 0.
  - Synchroniser flops 0.

## Timing
- A rising edge of `agc_clk_in` produces `tick` 3 `clk` cycles later. Strobes change 1 cycle after `tick`.
- `agc_clk_in` must stay high ≥2 and low ≥2 `clk` periods.
- After reset or enable: `dkstrt` first rises `SLOT_LEN` ticks later and lasts `PULSE_LEN` ticks.
- Frame period: `SLOT_LEN`·`FRAME_SLOTS` ticks. The END slot falls `SLOT_LEN`·41 ticks after the START slot begins.
- Commit: `word_valid` rises 1 cycle after the commit `tick`.

## Test plan
- **Default frame timing:** defaults, `enable`=1, `agc_clk_in` period 8 `clk`.
  - `dkstrt` high for 4 ticks starting at tick 20.
  - Then 40 `dkbsnc` pulses of 4 ticks, one every 20 ticks.
  - `dkend` starts at tick 840.
  - Next `dkstrt` at tick 20500.
- **Data capture:** drive `dkdata` with pattern 40'hA5_0F3C_1234 MSB-first, each bit valid across its strobe → `word_data`=40'hA50F3C1234, `word_valid`=1, `frame_count`=1.
- **Overrun:** hold `word_ready`=0 for two frames.
  - Result: first word retained, `overrun`=1, `frame_count`=2.
  - Then `overrun_clr` → `overrun`=0.
  - Then `word_ready`=1 → `word_valid` falls.
- **Commit/accept collision:** `word_valid`=1 with `word_ready` pulsed exactly in the commit cycle → new word loaded, `word_valid` stays 1, `overrun`=0.
- **Abort on disable:** drop `enable` at bit 17.
  - Strobes go low at once; no commit; `frame_count` unchanged.
  - Re-enable → `dkstrt` after 20 ticks and a clean full frame is captured.
- **Async reset mid-frame:** assert `rst` during BITS → all outputs 0 immediately, and `dkstrt` appears 20 ticks after release.

Source files
------------

// File: rtl/downlink_sequencer.sv
// Downlink PCM sequencer: derives strobe timing from the AGC clock, shifts in
// the 40 DKDATA bits of each frame and hands each word out over valid/ready.
module downlink_sequencer #(
    parameter int PULSE_LEN   = 4,
    parameter int SLOT_LEN    = 20,
    parameter int FRAME_SLOTS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        agc_clk_in,
    input  logic        dkdata,
    input  logic        word_ready,
    input  logic        overrun_clr,
    output logic        dkstrt,
    output logic        dkbsnc,
    output logic        dkend,
    output logic [39:0] word_data,
    output logic        word_valid,
    output logic        overrun,
    output logic [15:0] frame_count
);

    localparam int PW = $clog2(SLOT_LEN);
    localparam int SW = $clog2(FRAME_SLOTS);

    localparam logic [PW-1:0] PULSE_LAST = PW'(SLOT_LEN - 1);
    localparam logic [PW-1:0] PULSE_CAP  = PW'(PULSE_LEN - 1);
    localparam logic [PW-1:0] PULSE_END  = PW'(PULSE_LEN);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(FRAME_SLOTS - 1);
    localparam logic [5:0]    BIT_FIRST  = 6'd1;
    localparam logic [5:0]    BIT_LAST   = 6'd40;
    localparam logic [5:0]    BIT_END    = 6'd41;
    localparam logic [5:0]    BIT_GAP    = 6'd42;

    logic [2:0]    agc_sync_q, agc_sync_d;
    logic [1:0]    dk_sync_q, dk_sync_d;
    logic [PW-1:0] pulse_q, pulse_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [5:0]    bit_q, bit_d;
    logic [39:0]   shreg_q, shreg_d;
    logic [39:0]   word_data_q, word_data_d;
    logic          word_valid_q, word_valid_d;
    logic          overrun_q, overrun_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    logic tick, dk_s, in_pulse, in_bits, capture, commit, drop;

    // The DKDATA path has the same depth as the clock path up to tick, so the
    // sampled bit belongs to the same AGC clock edge that produced tick.
    assign tick     = agc_sync_q[1] & ~agc_sync_q[2];
    assign dk_s     = dk_sync_q[1];
    assign in_pulse = pulse_q < PULSE_END;
    assign in_bits  = (bit_q >= BIT_FIRST) && (bit_q <= BIT_LAST);
    assign capture  = enable & tick & (pulse_q == PULSE_CAP);
    assign commit   = capture & (bit_q == BIT_END);
    assign drop     = commit & word_valid_q & ~word_ready;

    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        agc_sync_d   = {agc_sync_q[1:0], agc_clk_in};
        dk_sync_d    = {dk_sync_q[0], dkdata};
        pulse_d      = pulse_q;
        slot_d       = slot_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        word_data_d  = word_data_q;
        word_valid_d = word_valid_q;
        frame_cnt_d  = frame_cnt_q;
        overrun_d    = overrun_q;

        if (!enable) begin
            pulse_d = '0;
            slot_d  = SLOT_LAST;
            bit_d   = BIT_GAP;
            shreg_d = '0;
        end else if (tick) begin
            if (pulse_q == PULSE_LAST) begin
                pulse_d = '0;
                if (slot_q == SLOT_LAST) begin
                    slot_d = '0;
                    bit_d  = '0;
                end else begin
                    slot_d = slot_q + SW'(1);
                    if (bit_q < BIT_GAP) begin
                        bit_d = bit_q + 6'd1;
                    end
                end
            end else begin
                pulse_d = pulse_q + PW'(1);
            end
            if (capture && in_bits) begin
                shreg_d = {shreg_q[38:0], dk_s};
            end
        end

        if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
        end
        if (commit) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (!drop) begin
                word_data_d  = shreg_q;
                word_valid_d = 1'b1;
            end
        end

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            agc_sync_q   <= '0;
            dk_sync_q    <= '0;
            pulse_q      <= '0;
            slot_q       <= SLOT_LAST;
            bit_q        <= BIT_GAP;
            shreg_q      <= '0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            agc_sync_q   <= agc_sync_d;
            dk_sync_q    <= dk_sync_d;
            pulse_q      <= pulse_d;
            slot_q       <= slot_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
            overrun_q    <= overrun_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign dkstrt      = enable & in_pulse & (bit_q == 6'd0);
    assign dkbsnc      = enable & in_pulse & in_bits;
    assign dkend       = enable & in_pulse & (bit_q == BIT_END);
    assign word_data   = word_data_q;
    assign word_valid  = word_valid_q;
    assign overrun     = overrun_q;
    assign frame_count = frame_cnt_q;

endmodule
